// File: rtl/l2_cache.sv
// Direct-mapped 32-line L2 cache with write-back, write-allocate (full-line) policy.
// Optional hit/miss performance counters are built when L2_PERF_CNT_EN is defined.
module l2_cache (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         l1_read,
  input  logic         l1_write,
  input  logic [27:0]  l1_addr,
  input  logic [127:0] l1_wdata,
  output logic         l1_ready,
  output logic [127:0] l1_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITEBACK = 3'd1,
    S_WAIT      = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_next_s;

  logic [31:0]    valid_r;
  logic [31:0]    dirty_r;
  logic [22:0]    tag_mem_r  [32];
  logic [127:0]   data_mem_r [32];
  logic           op_write_r;

  logic [4:0]     idx_s;
  logic [22:0]    tag_s;
  logic           req_s;
  logic           hit_s;
  logic           victim_dirty_s;

  assign idx_s          = l1_addr[4:0];
  assign tag_s          = l1_addr[27:5];
  assign req_s          = l1_read | l1_write;
  assign hit_s          = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign victim_dirty_s = valid_r[idx_s] & dirty_r[idx_s];

  // State register
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!req_s) begin
          state_next_s = S_IDLE;
        end else if (hit_s) begin
          state_next_s = S_RESP;
        end else if (victim_dirty_s) begin
          state_next_s = S_WRITEBACK;
        end else if (l1_write) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_WRITEBACK;
        end
      end
      S_WAIT: begin
        if (op_write_r) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_ALLOCATE;
        end
      end
      S_RESP:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, so requests drop the cycle after mem_ready
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    l1_ready  = 1'b0;
    case (state_r)
      S_WRITEBACK: mem_write = 1'b1;
      S_ALLOCATE:  mem_read  = 1'b1;
      S_RESP:      l1_ready  = 1'b1;
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        l1_ready  = 1'b0;
      end
    endcase
  end

  // Line storage, read-data latch and memory request address/data
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      valid_r    <= 32'd0;
      dirty_r    <= 32'd0;
      l1_rdata   <= 128'd0;
      mem_addr   <= 28'd0;
      mem_wdata  <= 128'd0;
      op_write_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            op_write_r <= l1_write;
            if (hit_s) begin
              if (l1_write) begin
                data_mem_r[idx_s] <= l1_wdata;
                dirty_r[idx_s]    <= 1'b1;
              end else begin
                l1_rdata <= data_mem_r[idx_s];
              end
            end else if (victim_dirty_s) begin
              mem_addr  <= {tag_mem_r[idx_s], idx_s};
              mem_wdata <= data_mem_r[idx_s];
            end else if (l1_write) begin
              data_mem_r[idx_s] <= l1_wdata;
              tag_mem_r[idx_s]  <= tag_s;
              valid_r[idx_s]    <= 1'b1;
              dirty_r[idx_s]    <= 1'b1;
            end else begin
              mem_addr <= l1_addr;
            end
          end
        end
        S_WAIT: begin
          if (op_write_r) begin
            data_mem_r[idx_s] <= l1_wdata;
            tag_mem_r[idx_s]  <= tag_s;
            valid_r[idx_s]    <= 1'b1;
            dirty_r[idx_s]    <= 1'b1;
          end else begin
            mem_addr <= l1_addr;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            data_mem_r[idx_s] <= mem_rdata;
            tag_mem_r[idx_s]  <= tag_s;
            valid_r[idx_s]    <= 1'b1;
            dirty_r[idx_s]    <= 1'b0;
            l1_rdata          <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  // Saturating hit/miss counters, stepped only on lookups made in IDLE
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else if ((state_r == S_IDLE) && req_s) begin
      if (hit_s) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`else
  assign hit_cnt  = 16'd0;
  assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache with a fixed 3-cycle memory responder.
// Counter expectations follow the L2_PERF_CNT_EN build option.
module tb_l2_cache;

  logic         clk;
  logic         proc_reset;
  logic         l1_read;
  logic         l1_write;
  logic [27:0]  l1_addr;
  logic [127:0] l1_wdata;
  logic         l1_ready;
  logic [127:0] l1_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

`ifdef L2_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder bookkeeping
  int           rd_txn = 0;
  int           wr_txn = 0;
  logic [27:0]  last_rd_addr = 28'd0;
  logic [27:0]  last_wr_addr = 28'd0;
  logic [127:0] last_wr_data = 128'd0;
  int           neg_cnt = 0;
  int           busy = 0;
  int           wr_done_neg = -100;
  int           rd_start_neg = -100;
  logic         wait_busy = 1'b0;

  l2_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .l1_read    (l1_read),
    .l1_write   (l1_write),
    .l1_addr    (l1_addr),
    .l1_wdata   (l1_wdata),
    .l1_ready   (l1_ready),
    .l1_rdata   (l1_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory answers every request on its third requesting cycle
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      neg_cnt++;
      if (neg_cnt == wr_done_neg + 1) wait_busy = mem_read | mem_write;
      if (mem_read || mem_write) begin
        busy++;
        if (mem_read && busy == 1) rd_start_neg = neg_cnt;
        if (busy == 3) begin
          mem_ready = 1'b1;
          busy = 0;
          if (mem_read) begin
            rd_txn++;
            last_rd_addr = mem_addr;
          end else begin
            wr_txn++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            wr_done_neg  = neg_cnt;
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wd, input bit hold,
                        output int lat, output logic [127:0] line);
    l1_read  = rd;
    l1_write = wr;
    l1_addr  = addr;
    l1_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!l1_ready && lat < 60);
    if (!l1_ready) check_val("req_timeout", 128'd0, 128'd1);
    line = l1_rdata;
    if (hold) begin
      @(posedge clk); #1;
      l1_read  = 1'b0;
      l1_write = 1'b0;
    end else begin
      l1_read  = 1'b0;
      l1_write = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int           lat;
    int           rd0, wr0, rdy_seen;
    logic [127:0] line;

    proc_reset = 1'b1;
    l1_read    = 1'b0;
    l1_write   = 1'b0;
    l1_addr    = 28'd0;
    l1_wdata   = 128'd0;
    mem_rdata  = {16{8'hA5}};
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_l1_ready", {127'd0, l1_ready}, 128'd0);
    check_val("rst_mem_req", {126'd0, mem_read, mem_write}, 128'd0);
    check_val("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    check_val("rst_mem_wdata", mem_wdata, 128'd0);
    check_val("rst_l1_rdata", l1_rdata, 128'd0);
    check_val("rst_cnts", {96'd0, hit_cnt, miss_cnt}, 128'd0);
    proc_reset = 1'b0;
    @(posedge clk); #1;

    // cold read miss
    rd0 = rd_txn; wr0 = wr_txn;
    do_req(1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0, lat, line);
    check_val("miss_lat", lat, 128'd4);
    check_val("miss_rdata", line, {16{8'hA5}});
    check_val("miss_rd_txn", rd_txn - rd0, 128'd1);
    check_val("miss_wr_txn", wr_txn - wr0, 128'd0);
    check_val("miss_rd_addr", {100'd0, last_rd_addr}, 128'h0000010);
    check_val("miss_cnt1", {112'd0, miss_cnt}, PERF_EN ? 128'd1 : 128'd0);

    // repeat read hits
    rd0 = rd_txn;
    do_req(1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0, lat, line);
    check_val("hit_lat", lat, 128'd1);
    check_val("hit_rdata", line, {16{8'hA5}});
    check_val("hit_no_mem", rd_txn - rd0, 128'd0);
    check_val("hit_cnt1", {112'd0, hit_cnt}, PERF_EN ? 128'd1 : 128'd0);

    // clean write miss installs without memory traffic, l1_rdata untouched
    rd0 = rd_txn; wr0 = wr_txn;
    do_req(1'b0, 1'b1, 28'h0000030, 128'h1234, 1'b0, lat, line);
    check_val("wmiss_lat", lat, 128'd1);
    check_val("wmiss_no_mem", (rd_txn - rd0) + (wr_txn - wr0), 128'd0);
    check_val("wmiss_rdata_hold", line, {16{8'hA5}});
    do_req(1'b1, 1'b0, 28'h0000030, 128'd0, 1'b0, lat, line);
    check_val("wline_lat", lat, 128'd1);
    check_val("wline_rdata", line, 128'h1234);

    // dirty conflict read: writeback, one idle cycle, fill
    mem_rdata = {4{32'hDEADBEEF}};
    rd0 = rd_txn; wr0 = wr_txn;
    do_req(1'b1, 1'b0, 28'h0000050, 128'd0, 1'b0, lat, line);
    check_val("dirty_lat", lat, 128'd8);
    check_val("dirty_wr_txn", wr_txn - wr0, 128'd1);
    check_val("dirty_wr_addr", {100'd0, last_wr_addr}, 128'h0000030);
    check_val("dirty_wr_data", last_wr_data, 128'h1234);
    check_val("dirty_wait_gap", rd_start_neg - wr_done_neg, 128'd2);
    check_val("dirty_wait_idle", {127'd0, wait_busy}, 128'd0);
    check_val("dirty_rd_txn", rd_txn - rd0, 128'd1);
    check_val("dirty_rd_addr", {100'd0, last_rd_addr}, 128'h0000050);
    check_val("dirty_rdata", line, {4{32'hDEADBEEF}});

    // dirty write miss: writeback, wait, install, no fill
    do_req(1'b0, 1'b1, 28'h0000050, 128'h5050, 1'b0, lat, line);
    check_val("whit_lat", lat, 128'd1);
    rd0 = rd_txn; wr0 = wr_txn;
    do_req(1'b0, 1'b1, 28'h0000070, 128'h7070, 1'b0, lat, line);
    check_val("wdirty_lat", lat, 128'd5);
    check_val("wdirty_wr_txn", wr_txn - wr0, 128'd1);
    check_val("wdirty_rd_txn", rd_txn - rd0, 128'd0);
    check_val("wdirty_wr_addr", {100'd0, last_wr_addr}, 128'h0000050);
    check_val("wdirty_wr_data", last_wr_data, 128'h5050);
    do_req(1'b1, 1'b0, 28'h0000070, 128'd0, 1'b0, lat, line);
    check_val("wdirty_readback", line, 128'h7070);
    check_val("cnts_pre_rst", {96'd0, hit_cnt, miss_cnt},
              PERF_EN ? {96'd0, 16'd4, 16'd4} : 128'd0);

    // reset in the middle of an allocate
    l1_read = 1'b1;
    l1_addr = 28'h0000011;
    @(posedge clk); #1;
    check_val("alloc_mem_read", {127'd0, mem_read}, 128'd1);
    proc_reset = 1'b1;
    l1_read    = 1'b0;
    @(posedge clk); #1;
    check_val("rst_alloc_mem_read", {127'd0, mem_read}, 128'd0);
    check_val("rst_alloc_l1_ready", {127'd0, l1_ready}, 128'd0);
    proc_reset = 1'b0;
    @(posedge clk); #1;
    mem_rdata = {8{16'hC3C3}};
    rd0 = rd_txn;
    do_req(1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0, lat, line);
    check_val("post_rst_miss_lat", lat, 128'd4);
    check_val("post_rst_rd_txn", rd_txn - rd0, 128'd1);
    check_val("post_rst_rdata", line, {8{16'hC3C3}});

    // request held through the response: exactly one completion
    rd0 = rd_txn;
    do_req(1'b1, 1'b0, 28'h0000010, 128'd0, 1'b1, lat, line);
    check_val("hold_lat", lat, 128'd1);
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (l1_ready) rdy_seen++;
    end
    check_val("hold_no_second_ready", rdy_seen, 128'd0);
    check_val("hold_no_mem", rd_txn - rd0, 128'd0);

    // read and write together behave as a write
    do_req(1'b1, 1'b1, 28'h0000010, 128'h55, 1'b0, lat, line);
    check_val("rw_rdata_hold", line, {8{16'hC3C3}});
    do_req(1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0, lat, line);
    check_val("rw_readback", line, 128'h55);
    check_val("cnts_final", {96'd0, hit_cnt, miss_cnt},
              PERF_EN ? {96'd0, 16'd3, 16'd1} : 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_cache.md
L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port proc_reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port l1_read, input, 1 bit: L1 line-read request, held high until l1_ready.
REQ-004 SHALL have port l1_write, input, 1 bit: L1 line-writeback request, held high until l1_ready.
REQ-005 SHALL have port l1_addr, input, 28 bits: line address; index = [4:0], tag = [27:5].
REQ-006 SHALL have port l1_wdata, input, 128 bits: full line written by L1.
REQ-007 SHALL have port l1_ready, output, 1 bit: one-cycle completion pulse to L1.
REQ-008 SHALL have port l1_rdata, output, 128 bits: registered read line; valid during the l1_ready pulse of a read.
REQ-009 SHALL have port mem_read, output, 1 bit: line fill request to memory.
REQ-010 SHALL have port mem_write, output, 1 bit: line writeback request to memory.
REQ-011 SHALL have port mem_addr, output, 28 bits: memory line address.
REQ-012 SHALL have port mem_wdata, output, 128 bits: victim line data.
REQ-013 SHALL have port mem_rdata, input, 128 bits: fill data, valid when mem_ready is high.
REQ-014 SHALL have port mem_ready, input, 1 bit: one-cycle memory completion pulse.
REQ-015 SHALL have port hit_cnt, output, 16 bits: read/write hit count (see Configuration).
REQ-016 SHALL have port miss_cnt, output, 16 bits: read/write miss count (see Configuration).

Function
REQ-017 SHALL be direct-mapped: 32 lines of {valid, dirty, tag[22:0], data[127:0]}.
REQ-018 SHALL implement states IDLE, WRITEBACK, WAIT, ALLOCATE, RESP. In IDLE, l1_read or l1_write starts a lookup; with neither, it stays in IDLE.
REQ-019 Hit (valid and tag match) in IDLE: read latches the line into l1_rdata; write overwrites the whole line and sets dirty; next state RESP.
REQ-020 Write miss SHALL use full-line allocate with no memory fetch. If the victim is dirty: WRITEBACK, then WAIT, then install. Otherwise: install directly in IDLE with valid=1, dirty=1, then RESP.
REQ-021 Read miss: dirty victim goes to WRITEBACK; clean or invalid victim goes to ALLOCATE.
REQ-022 WRITEBACK SHALL drive mem_write=1, mem_addr={victim tag, index} and mem_wdata=victim data, and hold them until mem_ready is sampled high; the next state is then WAIT.
REQ-023 WAIT SHALL last exactly one cycle with mem_read=mem_write=0.
REQ-024 After WAIT: a read goes to ALLOCATE; a write installs the L1 line (valid=1, dirty=1) and goes to RESP.
REQ-025 ALLOCATE SHALL drive mem_read=1 and mem_addr=l1_addr until mem_ready is sampled high. On that edge it writes mem_rdata into the line (valid=1, dirty=0) and into l1_rdata, and goes to RESP.
REQ-026 RESP SHALL assert l1_ready for exactly one cycle, ignore all L1 requests, and return to IDLE.
REQ-027 mem_read, mem_write and l1_ready SHALL be decoded from state only; the memory request drops in the cycle after mem_ready.
REQ-028 Hit latency SHALL be l1_ready in cycle t+1 for a request first seen in IDLE at cycle t.
REQ-029 l1_rdata SHALL hold its value between reads; writes SHALL NOT change it.
REQ-030 If l1_read and l1_write are asserted together, the request SHALL be treated as a write.
REQ-031 mem_ready outside WRITEBACK or ALLOCATE SHALL be ignored.
REQ-032 l1_addr and l1_wdata SHALL be assumed stable from request until l1_ready.

Reset
REQ-033 proc_reset high at a clock edge SHALL force state IDLE and clear all valid and dirty bits.
REQ-034 The same reset SHALL force l1_ready, mem_read, mem_write, mem_addr, mem_wdata, l1_rdata, hit_cnt and miss_cnt to 0.
REQ-035 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction; the memory request drops in the cycle after reset.

Configuration
REQ-036 Macro L2_PERF_CNT_EN defined: hit_cnt increments once per IDLE hit, and miss_cnt once per IDLE miss. Both counters saturate at 16'hFFFF and never wrap.
REQ-037 Macro L2_PERF_CNT_EN undefined: hit_cnt and miss_cnt SHALL be tied to 0 and no counter logic is built.

Verification
REQ-038 After reset, read 28'h0000010 with memory returning 128'hA5..A5 after 3 cycles -> one mem_read transaction, then l1_ready with l1_rdata=128'hA5..A5; miss_cnt=1.
REQ-039 Repeat read 28'h0000010 -> l1_ready one cycle after the request, no memory activity, hit_cnt=1.
REQ-040 Write 28'h0000030 (index 16, clean) with data 128'h1234 -> no memory access, l1_ready in t+1; later read hits and returns 128'h1234.
REQ-041 Read 28'h0000050 (index 16, dirty conflict) -> mem_write to 28'h0000030 with 128'h1234, one idle WAIT cycle, mem_read 28'h0000050, then l1_ready.
REQ-042 Assert proc_reset during ALLOCATE -> mem_read=0 next cycle; the following read of 28'h0000010 misses.
REQ-043 Hold l1_read high one cycle past l1_ready -> no second lookup and no second l1_ready.
